// File: rtl/miniled_zone_tx.sv
// miniled_zone_tx: ping-pong zone buffer with serial mini-LED frame transmit; define ZONE_CLAMP_EN to saturate stored words at DUTY_MAX
module miniled_zone_tx #(
  parameter int TOTAL_BLOCKS = 360,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int CLK_DIV = 4,
  parameter int LAT_CYCLES = 8,
  parameter logic [DATA_W-1:0] DUTY_MAX = 'hF000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdbpflag,
  input  logic              wt_valid,
  input  logic [ADDR_W-1:0] wtaddr,
  input  logic [DATA_W-1:0] wtdina,
  output logic              sd_sclk,
  output logic              sd_sdi,
  output logic              sd_lat,
  output logic              busy,
  output logic              frame_done,
  output logic              stale,
  output logic [7:0]        drop_cnt
);
`ifdef ZONE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam int AW = $clog2(TOTAL_BLOCKS);
  localparam int PER = 2 * CLK_DIV;
  localparam int CW = $clog2((PER > LAT_CYCLES ? PER : LAT_CYCLES) + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [ADDR_W-1:0] NBLK = ADDR_W'(TOTAL_BLOCKS);
  localparam logic [ADDR_W-1:0] WLAST = ADDR_W'(TOTAL_BLOCKS - 1);
  localparam logic [AW-1:0] LAST = AW'(TOTAL_BLOCKS - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] PEND = CW'(PER - 1);
  localparam logic [CW-1:0] LATN = CW'(LAT_CYCLES);
  localparam logic [BW-1:0] BEND = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
  state_t state, state_d;

  logic [DATA_W-1:0] mem [0:1][0:TOTAL_BLOCKS-1];
  logic [DATA_W-1:0] shreg, wdata;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic flag_q, wr_bank, rd_bank, wr_complete, rd_valid, zero_mode;
  logic in_range, wr_ok, wr_last, accept, complete_now, bit_end, word_end;

  assign rd_bank = ~wr_bank;
  assign in_range = wtaddr < NBLK;
  assign wr_ok = wt_valid && in_range;
  assign wr_last = wr_ok && wtaddr == WLAST;
  assign complete_now = wr_complete || wr_last;
  assign accept = sdbpflag && !flag_q && state == IDLE;
  assign wdata = (CLAMP && wtdina > DUTY_MAX) ? DUTY_MAX : wtdina;

  // capture zone words into the bank currently being filled
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_bank][wtaddr[AW-1:0]] <= wdata;

  // request edge detect, bank swap decision and drop counting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flag_q <= 1'b0;
      wr_bank <= 1'b0;
      wr_complete <= 1'b0;
      rd_valid <= 1'b0;
      zero_mode <= 1'b0;
      stale <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      flag_q <= sdbpflag;
      if (wt_valid && !in_range && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (accept && complete_now) begin
        wr_bank <= ~wr_bank;
        wr_complete <= 1'b0;
        rd_valid <= 1'b1;
        zero_mode <= 1'b0;
        stale <= 1'b0;
      end else if (accept) begin
        stale <= 1'b1;
        zero_mode <= ~rd_valid;
      end else if (wr_last) wr_complete <= 1'b1;
    end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;

  // next state and serial outputs; shift outputs only exist in SHIFT so reset forces them low
  always_comb begin
    state_d = state;
    sd_sclk = 1'b0;
    sd_sdi = 1'b0;
    sd_lat = 1'b0;
    frame_done = 1'b0;
    busy = state != IDLE;
    bit_end = state == SHIFT && cnt == PEND;
    word_end = bit_end && bcnt == BEND;
    case (state)
      IDLE: state_d = accept ? LOAD : IDLE;
      LOAD: state_d = SHIFT;
      SHIFT: begin
        sd_sclk = cnt >= HALF;
        sd_sdi = shreg[DATA_W-1];
        if (word_end) state_d = rd_addr == LAST ? LATCH : LOAD;
      end
      LATCH: begin
        sd_lat = cnt < LATN;
        frame_done = cnt == LATN;
        busy = cnt != LATN;
        if (cnt == LATN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // read address, bit timing and shift register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_addr <= '0;
      cnt <= '0;
      bcnt <= '0;
      shreg <= '0;
    end else
      case (state)
        IDLE: begin
          rd_addr <= '0;
          cnt <= '0;
        end
        LOAD: begin
          shreg <= zero_mode ? '0 : mem[rd_bank][rd_addr];
          cnt <= '0;
          bcnt <= '0;
        end
        SHIFT:
          if (bit_end) begin
            cnt <= '0;
            shreg <= shreg << 1;
            bcnt <= bcnt + 1'b1;
            if (word_end && rd_addr != LAST) rd_addr <= rd_addr + 1'b1;
          end else cnt <= cnt + 1'b1;
        default: cnt <= cnt + 1'b1;
      endcase
endmodule

// File: tb/tb_miniled_zone_tx.sv
// tb_miniled_zone_tx: directed and randomized frames checked against a buffer-level reference model
module tb_miniled_zone_tx;
  localparam int NB = 360;
  localparam int DW = 16;
  localparam int AWD = 10;
  localparam int CD = 1;
  localparam int LC = 8;
  localparam int FLEN = NB * (2 * CD * DW + 1) + LC + 1;

  logic clk = 1'b0, rst_n = 1'b0, sdbpflag = 1'b0, wt_valid = 1'b0;
  logic [AWD-1:0] wtaddr = '0;
  logic [DW-1:0] wtdina = '0;
  logic sd_sclk, sd_sdi, sd_lat, busy, frame_done, stale;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  miniled_zone_tx #(.TOTAL_BLOCKS(NB), .DATA_W(DW), .ADDR_W(AWD), .CLK_DIV(CD), .LAT_CYCLES(LC)) dut (
    .clk(clk), .rst_n(rst_n), .sdbpflag(sdbpflag), .wt_valid(wt_valid), .wtaddr(wtaddr), .wtdina(wtdina),
    .sd_sclk(sd_sclk), .sd_sdi(sd_sdi), .sd_lat(sd_lat), .busy(busy), .frame_done(frame_done),
    .stale(stale), .drop_cnt(drop_cnt)
  );

  int total = 0, bad = 0;
  logic [DW-1:0] mbank [2][NB];
  logic [DW-1:0] expw [NB];
  bit mwb, mcomp, mrv, exp_stale;
  int mdrop;
  logic [DW-1:0] got [$];
  logic [DW-1:0] cur;
  int nb, lat_n, fd_n, len_n;
  logic sclk_q;

  // serial receiver: captures sd_sdi on each sd_sclk rise and counts latch/done/frame cycles
  always @(negedge clk)
    if (!rst_n) begin
      nb = 0;
      sclk_q = 1'b0;
    end else begin
      if (sd_sclk && !sclk_q) begin
        cur = {cur[DW-2:0], sd_sdi};
        nb++;
        if (nb == DW) begin
          got.push_back(cur);
          nb = 0;
        end
      end
      sclk_q = sd_sclk;
      if (sd_lat) lat_n++;
      if (frame_done) fd_n++;
      if (busy || frame_done) len_n++;
    end

  function automatic logic [DW-1:0] clampf(input logic [DW-1:0] d);
`ifdef ZONE_CLAMP_EN
    return d > 16'hF000 ? 16'hF000 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
    total++;
    assert (g === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, g, e);
    end
  endtask

  task automatic mwrite(input int a, input logic [DW-1:0] d);
    if (a < NB) begin
      mbank[mwb][a] = clampf(d);
      if (a == NB - 1) mcomp = 1'b1;
    end else if (mdrop < 255) mdrop++;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    wt_valid = 1'b1;
    wtaddr = AWD'(a);
    wtdina = d;
    mwrite(a, d);
    @(negedge clk);
    wt_valid = 1'b0;
  endtask

  task automatic start_frame(input bit w, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    got.delete();
    lat_n = 0;
    fd_n = 0;
    len_n = 0;
    sdbpflag = 1'b1;
    if (w) begin
      wt_valid = 1'b1;
      wtaddr = AWD'(a);
      wtdina = d;
      mwrite(a, d);
    end
    if (mcomp) begin
      mwb = !mwb;
      mcomp = 1'b0;
      mrv = 1'b1;
      exp_stale = 1'b0;
    end else exp_stale = 1'b1;
    for (int i = 0; i < NB; i++) expw[i] = mrv ? mbank[!mwb][i] : '0;
    @(negedge clk);
    sdbpflag = 1'b0;
    wt_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    for (int i = 0; i < 2 * FLEN && fd_n == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, fd_n, 1);
    chk({tag, "_lat_cycles"}, lat_n, LC);
    chk({tag, "_frame_len"}, len_n, FLEN);
    chk({tag, "_words"}, got.size(), NB);
    chk({tag, "_stale"}, stale, exp_stale);
    chk({tag, "_busy_idle"}, busy, 0);
    for (int i = 0; i < got.size() && i < NB; i++) chk($sformatf("%s_word%0d", tag, i), got[i], expw[i]);
  endtask

  initial begin
    mwb = 0; mcomp = 0; mrv = 0; mdrop = 0; cur = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sd_sclk, sd_sdi, sd_lat, busy, frame_done, stale}, 0);
    chk("reset_drop", drop_cnt, 0);
    rst_n = 1'b1;
    for (int a = 0; a < NB; a++) wr(a, DW'(a));
    start_frame(0, 0, 0);
    finish_frame("t1");
    chk("t1_last_word", got.size() == NB ? got[NB-1] : 16'hxxxx, 16'h0167);
    wr(360, 16'h1234);
    wr(1023, 16'h5678);
    chk("drop_two", drop_cnt, 2);
    for (int i = 0; i < 300; i++) wr(int'($urandom_range(1023, NB)), 16'($urandom));
    chk("drop_sat", drop_cnt, 255);
    chk("drop_model", drop_cnt, mdrop);
    for (int a = 0; a <= 100; a++) wr(a, 16'hAAAA);
    start_frame(0, 0, 0);
    repeat (500) @(negedge clk);
    sdbpflag = 1'b1;
    @(negedge clk);
    sdbpflag = 1'b0;
    finish_frame("t3");
    for (int a = 0; a < NB - 1; a++) wr(a, a == 5 ? 16'hFFFF : 16'($urandom));
    start_frame(1, NB - 1, 16'($urandom));
    for (int a = 0; a < NB; a++) wr(a, 16'($urandom));
    for (int i = 0; i < 5; i++) wr(int'($urandom_range(1023, NB)), 16'($urandom));
    finish_frame("rand_a");
`ifdef ZONE_CLAMP_EN
    chk("clamp_word5", got.size() > 5 ? got[5] : 16'hxxxx, 16'hF000);
`else
    chk("clamp_word5", got.size() > 5 ? got[5] : 16'hxxxx, 16'hFFFF);
`endif
    chk("drop_hold", drop_cnt, 255);
    start_frame(0, 0, 0);
    finish_frame("rand_b");
    start_frame(0, 0, 0);
    for (int i = 0; i < 2 * FLEN && !(got.size() == 200 && nb == 7); i++) @(negedge clk);
    chk("abort_reach", got.size() == 200 && nb == 7, 1);
    #3 rst_n = 1'b0;
    #1 chk("abort_async", {sd_sclk, sd_sdi, sd_lat, busy, frame_done}, 0);
    mwb = 0; mcomp = 0; mrv = 0; mdrop = 0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", fd_n, 0);
    chk("abort_no_lat", lat_n, 0);
    chk("abort_drop", drop_cnt, 0);
    chk("abort_stale", stale, 0);
    rst_n = 1'b1;
    start_frame(0, 0, 0);
    finish_frame("zero");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
